uart_rx_aux: RTL and testbench
==============================

Name: uart_rx_aux

Overview:
UART receiver matching the team's auxiliary 16x-oversampled transmitter. Frame format is 1 start bit (0), 8 data bits LSB first, 1 parity slot and 1 stop bit (1).
- Samples the serial line at mid-bit using the shared baud tick strobe.
- Presents the received byte with a one-cycle done pulse, plus parity and framing status.
- Sits between the external rx pin and the interface/ALU control logic.

Parameters:
N_BITS_DATA, 8, data bits per frame
N_CONT_TICKS, 4, width of the tick and bit counters
TICKS_PER_BIT, 16, s_ticks strobes per bit period
PARITY_MODE, 0, parity slot check: 0 = slot must be 0, 1 = even parity, 2 = odd parity

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
s_ticks  in  1  one-clock strobe, TICKS_PER_BIT per bit period
rx_data_in  in  1  serial line, idle high, asynchronous to clock
rx_data_out  out  N_BITS_DATA  last received byte
rx_done  out  1  one-cycle pulse: rx_data_out and error flags valid
parity_err  out  1  parity slot mismatch for the last frame
frame_err  out  1  stop bit sampled 0 for the last frame
rx_busy  out  1  high in any state except Idle

Behaviour:
- Input synchronizer: 2 flops, both reset to 1. All decisions use the synchronized line (rxs). This adds 2 clocks of line latency.
- Reset values (asynchronous assertion): rx_data_out = 0, rx_done = 0, parity_err = 0, frame_err = 0, rx_busy = 0, state = Idle, counters = 0, shift register = 0.
- Tick counter: advances only on s_ticks. It clears on every state change and in Idle.
- States are one-hot: Idle, Start, Data, Parity, Stop, Break.
  - Idle: when rxs = 0, go to Start with tick count 0.
  - Start: on the s_ticks that makes tick count reach TICKS_PER_BIT/2 - 1 (7):
    - If rxs = 0, clear the tick count and go to Data.
    - If rxs = 1, treat it as a glitch: return to Idle, with no rx_done and no flag change.
  - Data: on the s_ticks where tick count = TICKS_PER_BIT - 1 (15):
    - Shift rxs into the shift register MSB, shifting right, so the first bit ends in the LSB.
    - Increment the bit count and clear the tick count.
    - After N_BITS_DATA bits, go to Parity.
  - Parity: at tick 15, sample rxs into the parity bit and go to Stop.
  - Stop: at tick 15, sample rxs. In that same clock:
    - Load rx_data_out from the shift register.
    - Compute parity_err: mode 0 gives sampled bit != 0; mode 1 gives XOR(data, parity bit) != 0; mode 2 gives XOR(data, parity bit) != 1.
    - Set frame_err = ~rxs.
    - Register rx_done = 1; it is visible the following cycle for exactly one clock.
    - Next state is Idle if rxs = 1, else Break.
  - Break: wait until rxs = 1, then go to Idle. This prevents a held-low line from retriggering a start. No further rx_done while in Break.
- rx_data_out, parity_err and frame_err hold their values until the next completed frame. They are updated even when an error occurs, and rx_done pulses regardless of errors.
- s_ticks while the line is idle has no effect. A missing s_ticks simply stalls the counters.
- Reset mid-frame aborts immediately: no rx_done, and all outputs go to their reset values.
- Latency: the rx_done rising edge comes 1 clock after the s_ticks that samples the stop bit, which is about 10.5 bit periods after the start edge plus 2 synchronizer clocks.
- Tick counter wrap at TICKS_PER_BIT - 1 back to 0 requires TICKS_PER_BIT <= 2^N_CONT_TICKS.

Decomposition:
Shared package uart_aux_pkg holds:
- State encodings (one-hot, N_BITS_STATE = 6 for RX).
- TICKS_PER_BIT.
- Frame bit indices: START = 0, DATA = 8, PARITY = 9, STOP = 10.
- PARITY_MODE codes.

One natural sub-module, uart_rx_sync: the 2-flop synchronizer with reset-to-1. Everything else stays in uart_rx_aux.

Test Plan:
1. Tick every 4 clocks, frame 0xA5 with parity slot 0 and stop 1, PARITY_MODE = 0 -> single rx_done pulse; rx_data_out = 0xA5; parity_err = 0; frame_err = 0; rx_busy low after the pulse.
2. Line low for 5 ticks then high (glitch) -> return to Idle, no rx_done; then a valid frame 0x3C is received correctly.
3. Frame 0x81 with stop bit 0, line held low for 3 bit times -> rx_done once; rx_data_out = 0x81; frame_err = 1; no second rx_done until the line goes high and a new frame starts.
4. PARITY_MODE = 1: frame 0x07 with parity bit 1 -> parity_err = 0; same frame with parity bit 0 -> parity_err = 1, rx_data_out = 0x07.
5. Assert reset during data bit 4 of a frame -> all outputs immediately 0, no rx_done; the following frame 0xFF is received correctly.
6. Back-to-back frames 0x00 then 0xFF with no idle gap -> two rx_done pulses exactly 11 bit periods apart, values 0x00 then 0xFF, no errors.

Source files
------------

// File: rtl/uart_aux_pkg.sv
// Shared definitions for the auxiliary UART: receiver state encoding,
// bit timing, frame layout and parity-slot check modes.
package uart_aux_pkg;

  localparam int N_BITS_STATE  = 6;
  localparam int TICKS_PER_BIT = 16;

  localparam int FRAME_START  = 0;
  localparam int FRAME_DATA   = 8;
  localparam int FRAME_PARITY = 9;
  localparam int FRAME_STOP   = 10;

  localparam int PAR_ZERO = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [N_BITS_STATE-1:0] {
    S_IDLE   = 6'b000001,
    S_START  = 6'b000010,
    S_DATA   = 6'b000100,
    S_PARITY = 6'b001000,
    S_STOP   = 6'b010000,
    S_BREAK  = 6'b100000
  } rx_state_t;

  // data_xor is the XOR of all received data bits, slot the parity slot.
  function automatic logic parity_fail(
    input int   mode,
    input logic data_xor,
    input logic slot
  );
    if (mode == PAR_EVEN)
      return data_xor ^ slot;
    else if (mode == PAR_ODD)
      return ~(data_xor ^ slot);
    else
      return slot;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pin; resets to idle-high.
// Ports: clock, reset (async high), din (raw line), dout (synchronized).
module uart_rx_sync (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      dout <= 1'b1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_aux.sv
// 16x-oversampled UART receiver: start, 8 data LSB first, parity slot, stop.
// Ports: clock, reset, s_ticks, rx_data_in -> rx_data_out, rx_done,
// parity_err, frame_err, rx_busy.
module uart_rx_aux #(
  parameter int N_BITS_DATA   = 8,
  parameter int N_CONT_TICKS  = 4,
  parameter int TICKS_PER_BIT = uart_aux_pkg::TICKS_PER_BIT,
  parameter int PARITY_MODE   = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   s_ticks,
  input  logic                   rx_data_in,
  output logic [N_BITS_DATA-1:0] rx_data_out,
  output logic                   rx_done,
  output logic                   parity_err,
  output logic                   frame_err,
  output logic                   rx_busy
);

  import uart_aux_pkg::*;

  localparam logic [N_CONT_TICKS-1:0] T_HALF =
    N_CONT_TICKS'(TICKS_PER_BIT / 2 - 1);
  localparam logic [N_CONT_TICKS-1:0] T_LAST =
    N_CONT_TICKS'(TICKS_PER_BIT - 1);
  localparam logic [N_CONT_TICKS-1:0] B_LAST =
    N_CONT_TICKS'(N_BITS_DATA - 1);

  rx_state_t                state;
  logic [N_CONT_TICKS-1:0]  tick_cnt;
  logic [N_CONT_TICKS-1:0]  bit_cnt;
  logic [N_BITS_DATA-1:0]   shreg;
  logic                     par_bit;
  logic                     rxs;

  uart_rx_sync u_sync (
    .clock (clock),
    .reset (reset),
    .din   (rx_data_in),
    .dout  (rxs)
  );

  assign rx_busy = (state != S_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      rx_data_out <= '0;
      rx_done     <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        S_IDLE: begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
          if (!rxs)
            state <= S_START;
        end
        // Re-check the line at mid start bit to reject glitches.
        S_START: begin
          if (s_ticks) begin
            if (tick_cnt == T_HALF) begin
              tick_cnt <= '0;
              state    <= rxs ? S_IDLE : S_DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (s_ticks) begin
            if (tick_cnt == T_LAST) begin
              tick_cnt <= '0;
              shreg    <= {rxs, shreg[N_BITS_DATA-1:1]};
              if (bit_cnt == B_LAST) begin
                bit_cnt <= '0;
                state   <= S_PARITY;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (s_ticks) begin
            if (tick_cnt == T_LAST) begin
              tick_cnt <= '0;
              par_bit  <= rxs;
              state    <= S_STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (s_ticks) begin
            if (tick_cnt == T_LAST) begin
              tick_cnt    <= '0;
              rx_data_out <= shreg;
              parity_err  <= parity_fail(PARITY_MODE, ^shreg, par_bit);
              frame_err   <= ~rxs;
              rx_done     <= 1'b1;
              state       <= rxs ? S_IDLE : S_BREAK;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        // Held-low line must return high before a new start is accepted.
        S_BREAK: begin
          tick_cnt <= '0;
          if (rxs)
            state <= S_IDLE;
        end
        default: begin
          tick_cnt <= '0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_aux.sv
// Randomized bench for uart_rx_aux in all three parity modes at once.
// Frames are built bit-by-bit and checked against a frame-level model.
module tb_uart_rx_aux;

  logic       clock;
  logic       reset;
  logic       s_ticks;
  logic       rx;
  logic [7:0] dout [3];
  logic       done [3];
  logic       perr [3];
  logic       ferr [3];
  logic       busy [3];

  typedef struct {
    logic [7:0]  data;
    logic        par;
    logic        stop;
    int unsigned tick;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned tick_num;
  int          n_vec;
  int          n_err;
  int          ph;
  logic        prev_done;

  for (genvar m = 0; m < 3; m++) begin : g_dut
    uart_rx_aux #(.PARITY_MODE(m)) u_dut (
      .clock       (clock),
      .reset       (reset),
      .s_ticks     (s_ticks),
      .rx_data_in  (rx),
      .rx_data_out (dout[m]),
      .rx_done     (done[m]),
      .parity_err  (perr[m]),
      .frame_err   (ferr[m]),
      .rx_busy     (busy[m])
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    s_ticks = 1'b0;
    ph      = 0;
    forever begin
      @(negedge clock);
      ph      = (ph + 1) % 4;
      s_ticks = (ph == 0);
    end
  end

  initial tick_num = 0;
  always @(posedge clock)
    if (s_ticks) tick_num <= tick_num + 1;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_perr(int m, logic [7:0] d, logic p);
    if (m == 1) return (^d) ^ p;
    if (m == 2) return ~((^d) ^ p);
    return p;
  endfunction

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clock); while (!s_ticks);
      @(negedge clock);
    end
  endtask

  task automatic send(
    input logic [7:0] d,
    input logic       p,
    input logic       stop,
    input int         hold
  );
    exp_t e;
    e.data = d;
    e.par  = p;
    e.stop = stop;
    e.tick = tick_num + 168;
    exp_q.push_back(e);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    rx = p;
    wait_ticks(16);
    rx = stop;
    wait_ticks(16);
    if (!stop) begin
      wait_ticks(16 * hold);
      rx = 1'b1;
      wait_ticks(1);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!reset && (done[0] || done[1] || done[2])) begin
      check("done_all", 32'({done[2], done[1], done[0]}), 32'h7);
      check("done_width", 32'(prev_done), 32'h0);
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'(exp_q.size()), 32'h1);
      end else begin
        e = exp_q.pop_front();
        check("done_tick", 32'(tick_num), 32'(e.tick));
        for (int m = 0; m < 3; m++) begin
          check($sformatf("data_m%0d", m), 32'(dout[m]), 32'(e.data));
          check($sformatf("perr_m%0d", m), 32'(perr[m]),
                32'(exp_perr(m, e.data, e.par)));
          check($sformatf("ferr_m%0d", m), 32'(ferr[m]), 32'(!e.stop));
          check($sformatf("busy_m%0d", m), 32'(busy[m]), 32'(!e.stop));
        end
      end
    end
    prev_done = done[0];
  end

  task automatic check_cleared(input string tag);
    for (int m = 0; m < 3; m++) begin
      check({tag, "_data"}, 32'(dout[m]), 32'h0);
      check({tag, "_done"}, 32'(done[m]), 32'h0);
      check({tag, "_perr"}, 32'(perr[m]), 32'h0);
      check({tag, "_ferr"}, 32'(ferr[m]), 32'h0);
      check({tag, "_busy"}, 32'(busy[m]), 32'h0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    n_vec     = 0;
    n_err     = 0;
    prev_done = 1'b0;
    reset     = 1'b1;
    rx        = 1'b1;
    repeat (5) @(negedge clock);
    check_cleared("rst");
    reset = 1'b0;
    wait_ticks(3);

    send(8'hA5, 1'b0, 1'b1, 0);
    wait_ticks(4);
    check("idle_after_a5", 32'(busy[0]), 32'h0);

    rx = 1'b0;
    wait_ticks(5);
    check("glitch_busy", 32'(busy[0]), 32'h1);
    rx = 1'b1;
    wait_ticks(10);
    check("glitch_idle", 32'(busy[0]), 32'h0);
    send(8'h3C, 1'b0, 1'b1, 0);
    wait_ticks(2);

    send(8'h81, 1'b0, 1'b0, 3);
    wait_ticks(2);

    send(8'h07, 1'b1, 1'b1, 0);
    send(8'h07, 1'b0, 1'b1, 0);
    wait_ticks(2);

    d  = 8'h5A;
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    rx = d[4];
    wait_ticks(6);
    reset = 1'b1;
    #1;
    check_cleared("midrst");
    rx = 1'b1;
    wait_ticks(2);
    reset = 1'b0;
    wait_ticks(4);
    send(8'hFF, 1'b0, 1'b1, 0);
    wait_ticks(3);

    send(8'h00, 1'b0, 1'b1, 0);
    send(8'hFF, 1'b0, 1'b1, 0);
    wait_ticks(2);

    for (int k = 0; k < 20; k++) begin
      send(8'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0), $urandom_range(0, 2));
      wait_ticks($urandom_range(0, 3));
    end

    wait_ticks(8);
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
